// File: rtl/u110_ata_pio_timing_if.sv
// U110 ATA PIO sequencer bus bundle.
// Carries the decoded 68040 request (TSn, ATA_SEL, RnW, REG_SEL), the drive
// IORDY line, and every strobe/status output of the sequencer.
// master = request/drive side (bench or decode logic), slave = sequencer.
`timescale 1ns/1ps

interface u110_ata_pio_timing_if;
    // Request side and drive handshake
    logic TSn;
    logic ATA_SEL;
    logic RnW;
    logic REG_SEL;
    logic IORDY;

    // Sequencer outputs
    logic ATA_CS0n;
    logic ATA_CS1n;
    logic DIORn;
    logic DIOWn;
    logic ATA_TACK;
    logic ATA_BUSY;
    logic IORDY_TO;

    modport master (
        output TSn,
        output ATA_SEL,
        output RnW,
        output REG_SEL,
        output IORDY,
        input  ATA_CS0n,
        input  ATA_CS1n,
        input  DIORn,
        input  DIOWn,
        input  ATA_TACK,
        input  ATA_BUSY,
        input  IORDY_TO
    );

    modport slave (
        input  TSn,
        input  ATA_SEL,
        input  RnW,
        input  REG_SEL,
        input  IORDY,
        output ATA_CS0n,
        output ATA_CS1n,
        output DIORn,
        output DIOWn,
        output ATA_TACK,
        output ATA_BUSY,
        output IORDY_TO
    );
endinterface

// File: rtl/u110_ata_pio_timing.sv
// U110 ATA PIO cycle sequencer.
// Turns a decoded 68040 access to ATA space into CS0n/CS1n/DIORn/DIOWn
// strobes with PIO timing counted in CLK40 clocks, then raises ATA_TACK for
// the cycle-termination stage.
// State flow: IDLE -> SETUP -> STROBE [-> WAIT] -> HOLD -> ACK [-> RECOVER] -> IDLE
// Optional feature macro: ATA_IORDY_EN
//   defined   : IORDY is synchronised, the WAIT state stretches the strobe and
//               IORDY_TO flags a wait that ran out after WAIT_MAX clocks.
//   undefined : IORDY is ignored, STROBE always lasts T2_CLKS, IORDY_TO = 0.
`timescale 1ns/1ps

module u110_ata_pio_timing #(
    parameter int T1_CLKS   = 3,
    parameter int T2_CLKS   = 7,
    parameter int T4_CLKS   = 1,
    parameter int TACK_CLKS = 2,
    parameter int REC_CLKS  = 4,
    parameter int WAIT_MAX  = 63
) (
    input  logic                    CLK40,
    input  logic                    RESET,
    u110_ata_pio_timing_if.slave    bus
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETUP   = 3'd1,
        ST_STROBE  = 3'd2,
`ifdef ATA_IORDY_EN
        ST_WAIT    = 3'd3,
`endif
        ST_HOLD    = 3'd4,
        ST_ACK     = 3'd5,
        ST_RECOVER = 3'd6
    } state_t;

    // Each state is entered with (length - 1) so it lasts exactly its length.
    localparam logic [7:0] LOAD_T1   = 8'(T1_CLKS - 1);
    localparam logic [7:0] LOAD_T2   = 8'(T2_CLKS - 1);
    localparam logic [7:0] LOAD_T4   = 8'(T4_CLKS - 1);
    localparam logic [7:0] LOAD_TACK = 8'(TACK_CLKS - 1);
    localparam logic [7:0] LOAD_REC  = 8'((REC_CLKS > 0) ? REC_CLKS - 1 : 0);
`ifdef ATA_IORDY_EN
    localparam logic [7:0] LOAD_WAIT = 8'(WAIT_MAX - 1);
`endif

    state_t     state;
    state_t     next_state;
    logic [7:0] cnt;
    logic [7:0] cnt_next;
    logic       rnw_q;
    logic       reg_sel_q;
    logic       start;
    logic       cs_active;
    logic       strobe_active;
    logic       iordy_sync;
    logic       timeout_flag;
    logic       timeout_set;

    // A cycle starts only on a qualified ATA decode hit.
    assign start = !bus.TSn && bus.ATA_SEL;

`ifdef ATA_IORDY_EN
    logic iordy_meta;

    // Two-flop synchroniser for the asynchronous drive IORDY line.
    always_ff @(posedge CLK40) begin
        if (RESET) begin
            iordy_meta <= 1'b0;
            iordy_sync <= 1'b0;
        end else begin
            iordy_meta <= bus.IORDY;
            iordy_sync <= iordy_meta;
        end
    end

    // The wait ran out without IORDY: latch the sticky timeout flag.
    assign timeout_set = (state == ST_WAIT) && (cnt == 8'd0) && !iordy_sync;

    // Sticky timeout flag, cleared only by reset.
    always_ff @(posedge CLK40) begin
        if (RESET) begin
            timeout_flag <= 1'b0;
        end else if (timeout_set) begin
            timeout_flag <= 1'b1;
        end
    end
`else
    logic unused_iordy;

    assign unused_iordy = bus.IORDY;
    assign iordy_sync   = 1'b1;
    assign timeout_set  = 1'b0;
    assign timeout_flag = 1'b0;
`endif

    // State register, state counter and the direction/register-block latch.
    always_ff @(posedge CLK40) begin
        if (RESET) begin
            state     <= ST_IDLE;
            cnt       <= 8'd0;
            rnw_q     <= 1'b0;
            reg_sel_q <= 1'b0;
        end else begin
            state <= next_state;
            cnt   <= cnt_next;
            if ((state == ST_IDLE) && start) begin
                rnw_q     <= bus.RnW;
                reg_sel_q <= bus.REG_SEL;
            end
        end
    end

    // Next-state and counter reload; requests while busy are simply dropped.
    always_comb begin
        next_state = state;
        cnt_next   = (cnt != 8'd0) ? cnt - 8'd1 : 8'd0;
        case (state)
            ST_IDLE: begin
                cnt_next = 8'd0;
                if (start) begin
                    next_state = ST_SETUP;
                    cnt_next   = LOAD_T1;
                end
            end
            ST_SETUP: begin
                if (cnt == 8'd0) begin
                    next_state = ST_STROBE;
                    cnt_next   = LOAD_T2;
                end
            end
            ST_STROBE: begin
                if (cnt == 8'd0) begin
`ifdef ATA_IORDY_EN
                    if (!iordy_sync) begin
                        next_state = ST_WAIT;
                        cnt_next   = LOAD_WAIT;
                    end else begin
                        next_state = ST_HOLD;
                        cnt_next   = LOAD_T4;
                    end
`else
                    next_state = ST_HOLD;
                    cnt_next   = LOAD_T4;
`endif
                end
            end
`ifdef ATA_IORDY_EN
            ST_WAIT: begin
                if (iordy_sync || (cnt == 8'd0)) begin
                    next_state = ST_HOLD;
                    cnt_next   = LOAD_T4;
                end
            end
`endif
            ST_HOLD: begin
                if (cnt == 8'd0) begin
                    next_state = ST_ACK;
                    cnt_next   = LOAD_TACK;
                end
            end
            ST_ACK: begin
                if (cnt == 8'd0) begin
                    if (REC_CLKS == 0) begin
                        next_state = ST_IDLE;
                        cnt_next   = 8'd0;
                    end else begin
                        next_state = ST_RECOVER;
                        cnt_next   = LOAD_REC;
                    end
                end
            end
            ST_RECOVER: begin
                if (cnt == 8'd0) begin
                    next_state = ST_IDLE;
                    cnt_next   = 8'd0;
                end
            end
            default: begin
                next_state = ST_IDLE;
                cnt_next   = 8'd0;
            end
        endcase
    end

    // Output decode: CS spans SETUP..HOLD, strobe only inside that window,
    // so only one CS and only one strobe can ever be low.
    always_comb begin
        cs_active     = 1'b0;
        strobe_active = 1'b0;
        case (state)
            ST_SETUP:  cs_active = 1'b1;
            ST_HOLD:   cs_active = 1'b1;
            ST_STROBE: begin
                cs_active     = 1'b1;
                strobe_active = 1'b1;
            end
`ifdef ATA_IORDY_EN
            ST_WAIT: begin
                cs_active     = 1'b1;
                strobe_active = 1'b1;
            end
`endif
            default: begin
                cs_active     = 1'b0;
                strobe_active = 1'b0;
            end
        endcase
        bus.ATA_CS0n = !(cs_active && !reg_sel_q);
        bus.ATA_CS1n = !(cs_active && reg_sel_q);
        bus.DIORn    = !(strobe_active && rnw_q);
        bus.DIOWn    = !(strobe_active && !rnw_q);
        bus.ATA_TACK = (state == ST_ACK);
        bus.ATA_BUSY = (state != ST_IDLE);
        bus.IORDY_TO = timeout_flag;
    end

endmodule

// File: tb/tb_u110_ata_pio_timing.sv
// Directed bench for the U110 ATA PIO sequencer (default parameters).
// Each cycle is captured as per-clock bit vectors: bit k holds an output as
// seen after the k-th rising edge counted from the edge that sampled TSn.
// Build with +define+ATA_IORDY_EN to exercise the IORDY wait/timeout path.
`timescale 1ns/1ps

module tb_u110_ata_pio_timing;

    logic CLK40 = 1'b0;
    logic RESET;

    u110_ata_pio_timing_if bus ();

    u110_ata_pio_timing dut (
        .CLK40 (CLK40),
        .RESET (RESET),
        .bus   (bus)
    );

    // 40 MHz clock.
    always #12.5 CLK40 = ~CLK40;

    int compared   = 0;
    int mismatched = 0;

    logic [127:0] cap_cs0, cap_cs1, cap_dior, cap_diow, cap_tack, cap_busy, cap_to;
    logic [127:0] m;
    logic [127:0] exp_v;

    function automatic logic [127:0] span(input int lo, input int hi);
        logic [127:0] v;
        v = '0;
        for (int i = lo; i <= hi; i++) v[i] = 1'b1;
        return v;
    endfunction

    // Start one access and record n clocks of outputs. Optional events (-1 = off):
    // a second TSn sampled at edge pulse_at, RESET sampled at edge reset_at,
    // IORDY first sampled low at edge iordy_fall and high again at iordy_rise.
    task automatic applyStimulus(input logic rnw, input logic reg_sel, input int n,
                                 input int pulse_at, input int reset_at,
                                 input int iordy_fall, input int iordy_rise);
        cap_cs0 = '0; cap_cs1 = '0; cap_dior = '0; cap_diow = '0;
        cap_tack = '0; cap_busy = '0; cap_to = '0;
        m = span(0, n - 1);
        @(negedge CLK40);
        bus.TSn = 1'b0; bus.ATA_SEL = 1'b1; bus.RnW = rnw; bus.REG_SEL = reg_sel;
        for (int k = 0; k < n; k++) begin
            @(negedge CLK40);
            cap_cs0[k]  = bus.ATA_CS0n;
            cap_cs1[k]  = bus.ATA_CS1n;
            cap_dior[k] = bus.DIORn;
            cap_diow[k] = bus.DIOWn;
            cap_tack[k] = bus.ATA_TACK;
            cap_busy[k] = bus.ATA_BUSY;
            cap_to[k]   = bus.IORDY_TO;
            if (k == 0) begin
                bus.TSn = 1'b1; bus.ATA_SEL = 1'b0;
                bus.RnW = ~rnw; bus.REG_SEL = ~reg_sel;
            end
            if (k + 1 == pulse_at) begin bus.TSn = 1'b0; bus.ATA_SEL = 1'b1; end
            if (k == pulse_at)     begin bus.TSn = 1'b1; bus.ATA_SEL = 1'b0; end
            if (k + 1 == reset_at) RESET = 1'b1;
            if (k == reset_at)     RESET = 1'b0;
            if (k + 1 == iordy_fall) bus.IORDY = 1'b0;
            if (k + 1 == iordy_rise) bus.IORDY = 1'b1;
        end
    endtask

    task automatic test_reset();
        logic [6:0] got;
        RESET = 1'b1;
        bus.TSn = 1'b1; bus.ATA_SEL = 1'b0; bus.RnW = 1'b1; bus.REG_SEL = 1'b0; bus.IORDY = 1'b1;
        repeat (3) @(negedge CLK40);
        got = {bus.ATA_CS0n, bus.ATA_CS1n, bus.DIORn, bus.DIOWn, bus.ATA_TACK, bus.ATA_BUSY, bus.IORDY_TO};
        compared++;
        if (got !== 7'b1111000) begin
            mismatched++;
            $display("[TB] FAIL reset_outputs got=%b want=%b", got, 7'b1111000);
        end
        RESET = 1'b0;
        repeat (3) @(negedge CLK40);
        compared++;
        if (bus.ATA_BUSY !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_release_busy got=%b want=0", bus.ATA_BUSY);
        end
    endtask

    task automatic test_read();
        applyStimulus(1'b1, 1'b0, 20, -1, -1, -1, -1);
        exp_v = ~span(0, 10) & m;
        compared++;
        if ((cap_cs0 & m) !== exp_v) begin mismatched++; $display("[TB] FAIL read_cs0n got=%h want=%h", cap_cs0 & m, exp_v); end
        exp_v = m;
        compared++;
        if ((cap_cs1 & m) !== exp_v) begin mismatched++; $display("[TB] FAIL read_cs1n got=%h want=%h", cap_cs1 & m, exp_v); end
        exp_v = ~span(3, 9) & m;
        compared++;
        if ((cap_dior & m) !== exp_v) begin mismatched++; $display("[TB] FAIL read_diorn got=%h want=%h", cap_dior & m, exp_v); end
        exp_v = m;
        compared++;
        if ((cap_diow & m) !== exp_v) begin mismatched++; $display("[TB] FAIL read_diown got=%h want=%h", cap_diow & m, exp_v); end
        exp_v = span(11, 12);
        compared++;
        if ((cap_tack & m) !== exp_v) begin mismatched++; $display("[TB] FAIL read_tack got=%h want=%h", cap_tack & m, exp_v); end
        exp_v = span(0, 16);
        compared++;
        if ((cap_busy & m) !== exp_v) begin mismatched++; $display("[TB] FAIL read_busy got=%h want=%h", cap_busy & m, exp_v); end
    endtask

    task automatic test_write();
        applyStimulus(1'b0, 1'b1, 20, -1, -1, -1, -1);
        exp_v = m;
        compared++;
        if ((cap_cs0 & m) !== exp_v) begin mismatched++; $display("[TB] FAIL write_cs0n got=%h want=%h", cap_cs0 & m, exp_v); end
        exp_v = ~span(0, 10) & m;
        compared++;
        if ((cap_cs1 & m) !== exp_v) begin mismatched++; $display("[TB] FAIL write_cs1n got=%h want=%h", cap_cs1 & m, exp_v); end
        exp_v = m;
        compared++;
        if ((cap_dior & m) !== exp_v) begin mismatched++; $display("[TB] FAIL write_diorn got=%h want=%h", cap_dior & m, exp_v); end
        exp_v = ~span(3, 9) & m;
        compared++;
        if ((cap_diow & m) !== exp_v) begin mismatched++; $display("[TB] FAIL write_diown got=%h want=%h", cap_diow & m, exp_v); end
        exp_v = span(11, 12);
        compared++;
        if ((cap_tack & m) !== exp_v) begin mismatched++; $display("[TB] FAIL write_tack got=%h want=%h", cap_tack & m, exp_v); end
        exp_v = span(0, 16);
        compared++;
        if ((cap_busy & m) !== exp_v) begin mismatched++; $display("[TB] FAIL write_busy got=%h want=%h", cap_busy & m, exp_v); end
    endtask

    task automatic test_sel_miss();
        logic [4:0] busy_seen;
        logic [4:0] cs_seen;
        bus.TSn = 1'b0; bus.ATA_SEL = 1'b0; bus.RnW = 1'b1; bus.REG_SEL = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge CLK40);
            busy_seen[k] = bus.ATA_BUSY;
            cs_seen[k]   = bus.ATA_CS0n & bus.ATA_CS1n;
        end
        bus.TSn = 1'b1;
        compared++;
        if (busy_seen !== 5'b00000) begin mismatched++; $display("[TB] FAIL miss_busy got=%b want=00000", busy_seen); end
        compared++;
        if (cs_seen !== 5'b11111) begin mismatched++; $display("[TB] FAIL miss_cs got=%b want=11111", cs_seen); end
    endtask

    task automatic test_back_to_back();
        applyStimulus(1'b1, 1'b0, 20, 5, -1, -1, -1);
        exp_v = ~span(3, 9) & m;
        compared++;
        if ((cap_dior & m) !== exp_v) begin mismatched++; $display("[TB] FAIL busy_ign_diorn got=%h want=%h", cap_dior & m, exp_v); end
        exp_v = span(11, 12);
        compared++;
        if ((cap_tack & m) !== exp_v) begin mismatched++; $display("[TB] FAIL busy_ign_tack got=%h want=%h", cap_tack & m, exp_v); end
        exp_v = span(0, 16);
        compared++;
        if ((cap_busy & m) !== exp_v) begin mismatched++; $display("[TB] FAIL busy_ign_busy got=%h want=%h", cap_busy & m, exp_v); end
        applyStimulus(1'b0, 1'b0, 20, -1, -1, -1, -1);
        exp_v = ~span(3, 9) & m;
        compared++;
        if ((cap_diow & m) !== exp_v) begin mismatched++; $display("[TB] FAIL next_diown got=%h want=%h", cap_diow & m, exp_v); end
        exp_v = ~span(0, 10) & m;
        compared++;
        if ((cap_cs0 & m) !== exp_v) begin mismatched++; $display("[TB] FAIL next_cs0n got=%h want=%h", cap_cs0 & m, exp_v); end
    endtask

    task automatic test_reset_mid();
        applyStimulus(1'b1, 1'b0, 12, -1, 8, -1, -1);
        exp_v = ~span(0, 7) & m;
        compared++;
        if ((cap_cs0 & m) !== exp_v) begin mismatched++; $display("[TB] FAIL rstmid_cs0n got=%h want=%h", cap_cs0 & m, exp_v); end
        exp_v = ~span(3, 7) & m;
        compared++;
        if ((cap_dior & m) !== exp_v) begin mismatched++; $display("[TB] FAIL rstmid_diorn got=%h want=%h", cap_dior & m, exp_v); end
        exp_v = '0;
        compared++;
        if ((cap_tack & m) !== exp_v) begin mismatched++; $display("[TB] FAIL rstmid_tack got=%h want=%h", cap_tack & m, exp_v); end
        exp_v = span(0, 7);
        compared++;
        if ((cap_busy & m) !== exp_v) begin mismatched++; $display("[TB] FAIL rstmid_busy got=%h want=%h", cap_busy & m, exp_v); end
        repeat (2) @(negedge CLK40);
        applyStimulus(1'b1, 1'b0, 20, -1, -1, -1, -1);
        exp_v = span(0, 16);
        compared++;
        if ((cap_busy & m) !== exp_v) begin mismatched++; $display("[TB] FAIL after_rst_busy got=%h want=%h", cap_busy & m, exp_v); end
        exp_v = span(11, 12);
        compared++;
        if ((cap_tack & m) !== exp_v) begin mismatched++; $display("[TB] FAIL after_rst_tack got=%h want=%h", cap_tack & m, exp_v); end
    endtask

`ifdef ATA_IORDY_EN
    task automatic test_iordy_wait();
        applyStimulus(1'b1, 1'b0, 25, -1, -1, 3, 13);
        exp_v = ~span(3, 14) & m;
        compared++;
        if ((cap_dior & m) !== exp_v) begin mismatched++; $display("[TB] FAIL wait_diorn got=%h want=%h", cap_dior & m, exp_v); end
        exp_v = ~span(0, 15) & m;
        compared++;
        if ((cap_cs0 & m) !== exp_v) begin mismatched++; $display("[TB] FAIL wait_cs0n got=%h want=%h", cap_cs0 & m, exp_v); end
        exp_v = span(16, 17);
        compared++;
        if ((cap_tack & m) !== exp_v) begin mismatched++; $display("[TB] FAIL wait_tack got=%h want=%h", cap_tack & m, exp_v); end
        exp_v = '0;
        compared++;
        if ((cap_to & m) !== exp_v) begin mismatched++; $display("[TB] FAIL wait_to got=%h want=%h", cap_to & m, exp_v); end
    endtask

    task automatic test_iordy_timeout();
        bus.IORDY = 1'b0;
        applyStimulus(1'b1, 1'b0, 85, -1, -1, -1, -1);
        bus.IORDY = 1'b1;
        exp_v = ~span(3, 72) & m;
        compared++;
        if ((cap_dior & m) !== exp_v) begin mismatched++; $display("[TB] FAIL tmo_diorn got=%h want=%h", cap_dior & m, exp_v); end
        exp_v = span(74, 75);
        compared++;
        if ((cap_tack & m) !== exp_v) begin mismatched++; $display("[TB] FAIL tmo_tack got=%h want=%h", cap_tack & m, exp_v); end
        exp_v = span(0, 79);
        compared++;
        if ((cap_busy & m) !== exp_v) begin mismatched++; $display("[TB] FAIL tmo_busy got=%h want=%h", cap_busy & m, exp_v); end
        exp_v = span(73, 84);
        compared++;
        if ((cap_to & m) !== exp_v) begin mismatched++; $display("[TB] FAIL tmo_flag got=%h want=%h", cap_to & m, exp_v); end
        repeat (3) @(negedge CLK40);
        applyStimulus(1'b1, 1'b0, 20, -1, -1, -1, -1);
        exp_v = m;
        compared++;
        if ((cap_to & m) !== exp_v) begin mismatched++; $display("[TB] FAIL tmo_sticky got=%h want=%h", cap_to & m, exp_v); end
        exp_v = ~span(3, 9) & m;
        compared++;
        if ((cap_dior & m) !== exp_v) begin mismatched++; $display("[TB] FAIL tmo_next_diorn got=%h want=%h", cap_dior & m, exp_v); end
    endtask
`else
    task automatic test_iordy_ignored();
        bus.IORDY = 1'b0;
        applyStimulus(1'b1, 1'b0, 20, -1, -1, -1, -1);
        bus.IORDY = 1'b1;
        exp_v = ~span(3, 9) & m;
        compared++;
        if ((cap_dior & m) !== exp_v) begin mismatched++; $display("[TB] FAIL noiordy_diorn got=%h want=%h", cap_dior & m, exp_v); end
        exp_v = span(11, 12);
        compared++;
        if ((cap_tack & m) !== exp_v) begin mismatched++; $display("[TB] FAIL noiordy_tack got=%h want=%h", cap_tack & m, exp_v); end
        exp_v = '0;
        compared++;
        if ((cap_to & m) !== exp_v) begin mismatched++; $display("[TB] FAIL noiordy_to got=%h want=%h", cap_to & m, exp_v); end
    endtask
`endif

    initial begin
        test_reset();
        test_read();
        test_write();
        test_sel_miss();
        test_back_to_back();
        test_reset_mid();
`ifdef ATA_IORDY_EN
        test_iordy_wait();
        test_iordy_timeout();
`else
        test_iordy_ignored();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
